iod_eye_train_ctrl: RTL and testbench
=====================================

IOD_EYE_TRAIN_CTRL -- requirements
Module: iod_eye_train_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 4, number of IOD lanes trained (legal 1..8).
REQ-002 Parameter TAP_BITS, default 7, delay-tap counter width; the sweep covers taps 0..2^TAP_BITS-1.
REQ-003 Parameter SETTLE_CYCLES, default 8, FAB_CLK cycles waited after each tap move or flag clear (legal 2..255).
REQ-004 FAB_CLK  input  1  sole clock; all logic on the rising edge.
REQ-005 ARST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 START  input  1  level; a rising edge sampled in IDLE, DONE or FAIL begins training.
REQ-007 EYE_MONITOR_EARLY  input  NUM_LANES  per-lane early flag from the IOD.
REQ-008 EYE_MONITOR_LATE  input  NUM_LANES  per-lane late flag from the IOD.
REQ-009 DELAY_LINE_OUT_OF_RANGE  input  NUM_LANES  per-lane delay-line limit flag.
REQ-010 DELAY_LINE_MOVE  output  NUM_LANES  one-cycle tap-step pulse; only the active lane bit may be set.
REQ-011 DELAY_LINE_DIRECTION  output  NUM_LANES  1 = increment, 0 = decrement; valid while MOVE is high.
REQ-012 DELAY_LINE_LOAD  output  NUM_LANES  one-cycle pulse that returns the lane tap to 0.
REQ-013 EYE_MONITOR_CLEAR_FLAGS  output  NUM_LANES  one-cycle flag-clear pulse.
REQ-014 TRAIN_BUSY / TRAIN_DONE / TRAIN_ERR  output  1 each  status; DONE and ERR are sticky until the next START.
REQ-015 ERR_LANES  output  NUM_LANES  bit set for each lane where no passing window was found.

Function
REQ-016 The FSM states shall be IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, CENTER, NEXT, DONE and FAIL.
REQ-017 Lanes shall be trained in order 0..NUM_LANES-1; exactly one lane is active at a time.
REQ-018 LOAD: pulse LOAD[lane] and set tap=0, win_start=0, win_len=0 and in_win=0.
REQ-019 CLEAR: pulse CLEAR_FLAGS[lane], then enter SETTLE for SETTLE_CYCLES cycles, then SAMPLE.
REQ-020 SAMPLE: the tap passes if EARLY[lane]=0 and LATE[lane]=0.
REQ-021 Window tracking: on the first pass set win_start=tap and in_win=1; each pass while in_win increments win_len; the first fail after in_win ends the sweep.
REQ-022 STEP: pulse MOVE[lane] with DIRECTION=1 and increment tap, then go to CLEAR.
REQ-023 The sweep shall also end when tap reaches 2^TAP_BITS-1 or OUT_OF_RANGE[lane] is sampled high; OUT_OF_RANGE takes priority over a same-cycle pass.
REQ-024 If the sweep ends with win_len=0, set ERR_LANES[lane] and go to NEXT.
REQ-025 Otherwise compute center = win_start + (win_len-1)>>1 at TAP_BITS+1 width without overflow; CENTER issues (tap - center) decrement MOVE pulses, each separated by SETTLE_CYCLES.
REQ-026 NEXT advances to the next lane; after the last lane go to FAIL if any ERR_LANES bit is set, otherwise DONE.
REQ-027 START edges while BUSY shall be ignored; a START that leaves DONE/FAIL clears DONE, ERR and ERR_LANES.
REQ-028 No two MOVE/LOAD pulses shall be closer than SETTLE_CYCLES+1 cycles.

Reset
REQ-029 When ARST_N=0, all outputs shall be 0, the FSM shall be IDLE and all counters 0, regardless of the current sweep.
REQ-030 Deassertion mid-training shall not resume training; a new START is required.

Configuration
REQ-031 With IOD_TRAIN_STATUS_EN defined, add output WIN_CENTER (NUM_LANES*TAP_BITS) and WIN_WIDTH (NUM_LANES*(TAP_BITS+1)), both captured per lane at NEXT and zero on reset or START.
REQ-032 Without IOD_TRAIN_STATUS_EN, those ports and their registers shall be absent and all other behaviour shall be identical.

Structure
REQ-033 The FSM state enum, the default parameter constants and the pass/fail encoding shall live in package iod_train_pkg.
REQ-034 The settle counter shall be a sub-module, iod_train_settle_timer (load/expire).

Verification
REQ-035 NUM_LANES=1, passing taps 10..20: expect LOAD, 21 sweep MOVEs up, 6 MOVEs down to center 15, then DONE=1 and ERR=0.
REQ-036 NUM_LANES=4, lane 2 always EARLY: expect ERR_LANES=4'b0100, FAIL state, and lanes 0, 1 and 3 centered.
REQ-037 Window 120..127 (TAP_BITS=7) reaching the end tap: expect sweep end at tap 127 and center 123.
REQ-038 OUT_OF_RANGE asserted at tap 50 with window starting at 45: expect win_len=5 and center 47.
REQ-039 ARST_N low during CENTER of lane 1: all outputs 0 next cycle; START then retrains from lane 0.
REQ-040 START pulsed while BUSY: no restart and no status change; measured MOVE spacing is at least SETTLE_CYCLES+1.

Source files
------------

// File: rtl/iod_train_pkg.sv
// Shared types, default parameters and sample classification for the IOD eye-training controller.
package iod_train_pkg;

  localparam int unsigned DefNumLanes     = 4;
  localparam int unsigned DefTapBits      = 7;
  localparam int unsigned DefSettleCycles = 8;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StClear,
    StSettle,
    StSample,
    StStep,
    StCenter,
    StNext,
    StDone,
    StFail
  } train_state_e;

  typedef enum logic [1:0] {
    SampleFail = 2'b00,
    SamplePass = 2'b01,
    SampleOor  = 2'b10
  } sample_e;

  // A delay-line limit outranks whatever the eye monitor reports on the same cycle.
  function automatic sample_e classify_sample(input logic early, input logic late,
                                              input logic oor);
    if (oor) begin
      return SampleOor;
    end
    if (!early && !late) begin
      return SamplePass;
    end
    return SampleFail;
  endfunction

endpackage

// File: rtl/iod_train_settle_timer.sv
// Settle down-counter: load_i arms it for Cycles cycles, expire_o is high once it has run out.
module iod_train_settle_timer #(
  parameter int unsigned Cycles = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic expire_o
);

  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 8'(Cycles - 1);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 8'd0);

endmodule

// File: rtl/iod_eye_train_ctrl.sv
// Per-lane IOD eye training: sweep taps upward, find the first passing window, park at its centre.
// Optional status outputs WIN_CENTER/WIN_WIDTH are built only with IOD_TRAIN_STATUS_EN defined.
module iod_eye_train_ctrl
  import iod_train_pkg::*;
#(
  parameter int unsigned NUM_LANES     = DefNumLanes,
  parameter int unsigned TAP_BITS      = DefTapBits,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST_N,
  input  logic                 START,
  input  logic [NUM_LANES-1:0] EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0] EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0] EYE_MONITOR_CLEAR_FLAGS,
  output logic                 TRAIN_BUSY,
  output logic                 TRAIN_DONE,
  output logic                 TRAIN_ERR,
  output logic [NUM_LANES-1:0] ERR_LANES
`ifdef IOD_TRAIN_STATUS_EN
  ,
  output logic [NUM_LANES*TAP_BITS-1:0]     WIN_CENTER,
  output logic [NUM_LANES*(TAP_BITS+1)-1:0] WIN_WIDTH
`endif
);

  localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned LenW  = TAP_BITS + 1;
  localparam logic [TAP_BITS-1:0] TapMax = '1;

  train_state_e state_d, state_q;

  logic [LaneW-1:0]     lane_d, lane_q;
  logic [TAP_BITS-1:0]  tap_d, tap_q;
  logic [TAP_BITS-1:0]  win_start_d, win_start_q;
  logic [LenW-1:0]      win_len_d, win_len_q;
  logic                 in_win_d, in_win_q;
  logic                 centering_d, centering_q;
  logic [NUM_LANES-1:0] err_lanes_d, err_lanes_q;
  logic                 done_d, done_q;
  logic                 err_d, err_q;
  logic                 start_q;

  logic [NUM_LANES-1:0] lane_sel;
  logic                 start_rise, start_go, last_lane;
  logic                 settle_load, settle_expired;
  sample_e              smp;
  logic                 sweep_end, in_win_upd;
  logic [TAP_BITS-1:0]  win_start_upd;
  logic [LenW-1:0]      win_len_upd, len_m1, center;
  logic                 at_center;

  iod_train_settle_timer #(
    .Cycles(SETTLE_CYCLES)
  ) u_settle (
    .clk_i   (FAB_CLK),
    .rst_ni  (ARST_N),
    .load_i  (settle_load),
    .expire_o(settle_expired)
  );

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_sel[i] = (lane_q == LaneW'(i));
    end
  end

  assign start_rise = START & ~start_q;
  assign start_go   = start_rise &
                      ((state_q == StIdle) | (state_q == StDone) | (state_q == StFail));
  assign last_lane  = (lane_q == LaneW'(NUM_LANES - 1));
  assign len_m1     = win_len_q - LenW'(1);
  assign center     = {1'b0, win_start_q} + (len_m1 >> 1);
  assign at_center  = ({1'b0, tap_q} <= center);

  // Window bookkeeping for the tap currently being sampled.
  always_comb begin
    smp = classify_sample(|(EYE_MONITOR_EARLY & lane_sel), |(EYE_MONITOR_LATE & lane_sel),
                          |(DELAY_LINE_OUT_OF_RANGE & lane_sel));
    in_win_upd    = in_win_q;
    win_start_upd = win_start_q;
    win_len_upd   = win_len_q;
    sweep_end     = 1'b0;
    unique case (smp)
      SampleOor: sweep_end = 1'b1;
      SamplePass: begin
        if (!in_win_q) begin
          win_start_upd = tap_q;
          in_win_upd    = 1'b1;
        end
        win_len_upd = win_len_q + LenW'(1);
      end
      default: sweep_end = in_win_q;
    endcase
    if (tap_q == TapMax) begin
      sweep_end = 1'b1;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StFail: if (start_rise) state_d = StLoad;
      StLoad:   state_d = StClear;
      StClear:  state_d = StSettle;
      StSettle: if (settle_expired) state_d = centering_q ? StCenter : StSample;
      StSample: begin
        if (!sweep_end) begin
          state_d = StStep;
        end else begin
          state_d = (win_len_upd == '0) ? StNext : StCenter;
        end
      end
      StStep:   state_d = StClear;
      StCenter: state_d = at_center ? StNext : StSettle;
      StNext: begin
        if (!last_lane) begin
          state_d = StLoad;
        end else begin
          state_d = (|err_lanes_q) ? StFail : StDone;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    DELAY_LINE_MOVE         = '0;
    DELAY_LINE_DIRECTION    = '0;
    DELAY_LINE_LOAD         = '0;
    EYE_MONITOR_CLEAR_FLAGS = '0;
    settle_load             = 1'b0;
    TRAIN_BUSY = !((state_q == StIdle) || (state_q == StDone) || (state_q == StFail));
    case (state_q)
      StLoad:  DELAY_LINE_LOAD = lane_sel;
      StClear: begin
        EYE_MONITOR_CLEAR_FLAGS = lane_sel;
        settle_load             = 1'b1;
      end
      StStep: begin
        DELAY_LINE_MOVE      = lane_sel;
        DELAY_LINE_DIRECTION = lane_sel;
      end
      StCenter: begin
        if (!at_center) begin
          DELAY_LINE_MOVE = lane_sel;
          settle_load     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign TRAIN_DONE = done_q;
  assign TRAIN_ERR  = err_q;
  assign ERR_LANES  = err_lanes_q;

  always_comb begin
    lane_d      = lane_q;
    tap_d       = tap_q;
    win_start_d = win_start_q;
    win_len_d   = win_len_q;
    in_win_d    = in_win_q;
    centering_d = centering_q;
    err_lanes_d = err_lanes_q;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      StIdle, StDone, StFail: begin
        if (start_rise) begin
          lane_d      = '0;
          err_lanes_d = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
        end
      end
      StLoad: begin
        tap_d       = '0;
        win_start_d = '0;
        win_len_d   = '0;
        in_win_d    = 1'b0;
        centering_d = 1'b0;
      end
      StSample: begin
        in_win_d    = in_win_upd;
        win_start_d = win_start_upd;
        win_len_d   = win_len_upd;
        if (sweep_end) begin
          if (win_len_upd == '0) begin
            err_lanes_d = err_lanes_q | lane_sel;
          end else begin
            centering_d = 1'b1;
          end
        end
      end
      StStep:   tap_d = tap_q + TAP_BITS'(1);
      StCenter: if (!at_center) tap_d = tap_q - TAP_BITS'(1);
      StNext: begin
        if (!last_lane) begin
          lane_d = lane_q + LaneW'(1);
        end else if (|err_lanes_q) begin
          err_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // start_q resets high so a START level held through reset is not taken as a new edge.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      lane_q      <= '0;
      tap_q       <= '0;
      win_start_q <= '0;
      win_len_q   <= '0;
      in_win_q    <= 1'b0;
      centering_q <= 1'b0;
      err_lanes_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      lane_q      <= lane_d;
      tap_q       <= tap_d;
      win_start_q <= win_start_d;
      win_len_q   <= win_len_d;
      in_win_q    <= in_win_d;
      centering_q <= centering_d;
      err_lanes_q <= err_lanes_d;
      done_q      <= done_d;
      err_q       <= err_d;
      start_q     <= START;
    end
  end

`ifdef IOD_TRAIN_STATUS_EN
  logic [NUM_LANES*TAP_BITS-1:0] win_center_d, win_center_q;
  logic [NUM_LANES*LenW-1:0]     win_width_d, win_width_q;

  always_comb begin
    win_center_d = win_center_q;
    win_width_d  = win_width_q;
    if (start_go) begin
      win_center_d = '0;
      win_width_d  = '0;
    end else if (state_q == StNext) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_sel[i]) begin
          win_center_d[i*TAP_BITS +: TAP_BITS] = (win_len_q == '0) ? '0 : center[TAP_BITS-1:0];
          win_width_d[i*LenW +: LenW]          = win_len_q;
        end
      end
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      win_center_q <= '0;
      win_width_q  <= '0;
    end else begin
      win_center_q <= win_center_d;
      win_width_q  <= win_width_d;
    end
  end

  assign WIN_CENTER = win_center_q;
  assign WIN_WIDTH  = win_width_q;
`else
  logic unused_start_go;
  assign unused_start_go = start_go;
`endif

endmodule

// File: tb/tb_iod_eye_train_ctrl.sv
// Bench for iod_eye_train_ctrl: delay-line/eye-monitor plant plus per-lane result scoreboard.
module tb_iod_eye_train_ctrl;

  localparam int NL     = 4;
  localparam int TB     = 7;
  localparam int SC     = 8;
  localparam int TapMax = 127;

  typedef struct {
    int lane;
    int up;
    int down;
    int fin;
    bit err;
    int width;
  } exp_t;

  logic          FAB_CLK = 1'b0;
  logic          ARST_N;
  logic          START;
  logic [NL-1:0] EYE_MONITOR_EARLY;
  logic [NL-1:0] EYE_MONITOR_LATE;
  logic [NL-1:0] DELAY_LINE_OUT_OF_RANGE;
  logic [NL-1:0] DELAY_LINE_MOVE;
  logic [NL-1:0] DELAY_LINE_DIRECTION;
  logic [NL-1:0] DELAY_LINE_LOAD;
  logic [NL-1:0] EYE_MONITOR_CLEAR_FLAGS;
  logic          TRAIN_BUSY;
  logic          TRAIN_DONE;
  logic          TRAIN_ERR;
  logic [NL-1:0] ERR_LANES;
`ifdef IOD_TRAIN_STATUS_EN
  logic [NL*TB-1:0]     WIN_CENTER;
  logic [NL*(TB+1)-1:0] WIN_WIDTH;
`endif

  iod_eye_train_ctrl #(
    .NUM_LANES    (NL),
    .TAP_BITS     (TB),
    .SETTLE_CYCLES(SC)
  ) dut (
    .FAB_CLK                (FAB_CLK),
    .ARST_N                 (ARST_N),
    .START                  (START),
    .EYE_MONITOR_EARLY      (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE       (EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_MOVE        (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION   (DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD        (DELAY_LINE_LOAD),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .TRAIN_BUSY             (TRAIN_BUSY),
    .TRAIN_DONE             (TRAIN_DONE),
    .TRAIN_ERR              (TRAIN_ERR),
    .ERR_LANES              (ERR_LANES)
`ifdef IOD_TRAIN_STATUS_EN
    ,
    .WIN_CENTER             (WIN_CENTER),
    .WIN_WIDTH              (WIN_WIDTH)
`endif
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Plant configuration: passing taps lo..hi, out-of-range at taps >= oor.
  int lo[NL];
  int hi[NL];
  int oor[NL];
  int ptap[NL];

  int cyc       = 0;
  int cur_lane  = 0;
  bit have_lane = 0;
  bit busy_prev = 0;
  int n_up      = 0;
  int n_dn      = 0;
  bit gap_valid = 0;
  int last_cyc  = 0;
  int min_gap   = 1000000;
  int bad_sel   = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t lane_expect(input int lane, input int l, input int h, input int o);
    exp_t e;
    int   endt, last, len, ctr;
    endt = (h >= TapMax) ? TapMax : h + 1;
    if (o < endt) endt = o;
    last = (o <= h) ? o - 1 : h;
    if (last > TapMax) last = TapMax;
    len  = (last >= l) ? last - l + 1 : 0;
    ctr  = (len > 0) ? l + (len - 1) / 2 : endt;
    e.lane  = lane;
    e.up    = endt;
    e.down  = endt - ctr;
    e.fin   = ctr;
    e.err   = (len == 0);
    e.width = len;
    return e;
  endfunction

  task automatic finalize_lane();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check_eq($sformatf("lane%0d_id", e.lane), cur_lane, e.lane);
    check_eq($sformatf("lane%0d_moves_up", e.lane), n_up, e.up);
    check_eq($sformatf("lane%0d_moves_down", e.lane), n_dn, e.down);
    check_eq($sformatf("lane%0d_final_tap", e.lane), ptap[cur_lane], e.fin);
  endtask

  function automatic int lane_of(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Monitor and delay-line plant, both evaluated on the falling edge.
  always @(negedge FAB_CLK) begin
    logic [NL-1:0] m;
    cyc++;
    if (!ARST_N) begin
      have_lane = 0;
      busy_prev = 0;
      gap_valid = 0;
    end else begin
      if (|DELAY_LINE_LOAD) begin
        if (have_lane) finalize_lane();
        cur_lane  = lane_of(DELAY_LINE_LOAD);
        have_lane = 1;
        n_up      = 0;
        n_dn      = 0;
      end
      if (busy_prev && !TRAIN_BUSY && have_lane) begin
        finalize_lane();
        have_lane = 0;
      end
      busy_prev = TRAIN_BUSY;
      if (|(DELAY_LINE_MOVE | DELAY_LINE_LOAD)) begin
        if (gap_valid && (cyc - last_cyc) < min_gap) min_gap = cyc - last_cyc;
        last_cyc  = cyc;
        gap_valid = 1;
      end
      m = '0;
      m[cur_lane] = 1'b1;
      if (|DELAY_LINE_MOVE && (!have_lane || (DELAY_LINE_MOVE & ~m) != '0)) bad_sel++;
      if (have_lane && DELAY_LINE_MOVE[cur_lane]) begin
        if (DELAY_LINE_DIRECTION[cur_lane]) n_up++;
        else n_dn++;
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (DELAY_LINE_LOAD[i]) ptap[i] = 0;
      else if (DELAY_LINE_MOVE[i]) ptap[i] = DELAY_LINE_DIRECTION[i] ? ptap[i] + 1 : ptap[i] - 1;
      EYE_MONITOR_EARLY[i]       = (ptap[i] < lo[i]);
      EYE_MONITOR_LATE[i]        = (ptap[i] > hi[i]);
      DELAY_LINE_OUT_OF_RANGE[i] = (ptap[i] >= oor[i]);
    end
  end

  task automatic set_lane(input int i, input int l, input int h, input int o);
    lo[i]  = l;
    hi[i]  = h;
    oor[i] = o;
  endtask

  task automatic push_run(output logic [NL-1:0] err_mask);
    exp_t e;
    err_mask = '0;
    for (int i = 0; i < NL; i++) begin
      e = lane_expect(i, lo[i], hi[i], oor[i]);
      exp_q.push_back(e);
      if (e.err) err_mask[i] = 1'b1;
    end
  endtask

  task automatic pulse_start();
    @(negedge FAB_CLK);
    START = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    START = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge FAB_CLK);
      if (!TRAIN_BUSY) return;
    end
    check_eq({tag, "_timeout"}, 1, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_move"}, int'(DELAY_LINE_MOVE), 0);
    check_eq({tag, "_dir"}, int'(DELAY_LINE_DIRECTION), 0);
    check_eq({tag, "_load"}, int'(DELAY_LINE_LOAD), 0);
    check_eq({tag, "_clear"}, int'(EYE_MONITOR_CLEAR_FLAGS), 0);
    check_eq({tag, "_busy"}, int'(TRAIN_BUSY), 0);
    check_eq({tag, "_done"}, int'(TRAIN_DONE), 0);
    check_eq({tag, "_err"}, int'(TRAIN_ERR), 0);
    check_eq({tag, "_err_lanes"}, int'(ERR_LANES), 0);
  endtask

  initial begin
    logic [NL-1:0] err_mask;
    bit            seen;
    ARST_N = 1'b0;
    START  = 1'b0;
    for (int i = 0; i < NL; i++) begin
      ptap[i] = 0;
      set_lane(i, 255, 254, 1000);
    end
    repeat (3) @(negedge FAB_CLK);
    check_outputs_zero("reset");
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    // Run A: ordinary windows, top-of-range window, out-of-range cut; START while busy.
    set_lane(0, 10, 20, 1000);
    set_lane(1, 30, 60, 1000);
    set_lane(2, 120, 127, 1000);
    set_lane(3, 45, 80, 50);
    push_run(err_mask);
    pulse_start();
    repeat (150) @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    @(negedge FAB_CLK);
    check_eq("busy_start_ignored_busy", int'(TRAIN_BUSY), 1);
    check_eq("busy_start_ignored_done", int'(TRAIN_DONE), 0);
    wait_idle("run_a", 30000);
    check_eq("run_a_done", int'(TRAIN_DONE), 1);
    check_eq("run_a_err", int'(TRAIN_ERR), 0);
    check_eq("run_a_err_lanes", int'(ERR_LANES), int'(err_mask));
`ifdef IOD_TRAIN_STATUS_EN
    check_eq("run_a_center0", int'(WIN_CENTER[0 +: TB]), 15);
    check_eq("run_a_center3", int'(WIN_CENTER[3*TB +: TB]), 47);
    check_eq("run_a_width0", int'(WIN_WIDTH[0 +: TB+1]), 11);
    check_eq("run_a_width3", int'(WIN_WIDTH[3*(TB+1) +: TB+1]), 5);
`endif

    // Run B: lane 2 never opens; single-tap and tap-0 windows elsewhere.
    set_lane(0, 0, 5, 1000);
    set_lane(1, 60, 100, 1000);
    set_lane(2, 255, 254, 1000);
    set_lane(3, 7, 7, 1000);
    push_run(err_mask);
    pulse_start();
    check_eq("start_clears_done", int'(TRAIN_DONE), 0);
    check_eq("start_sets_busy", int'(TRAIN_BUSY), 1);
    wait_idle("run_b", 30000);
    check_eq("run_b_err", int'(TRAIN_ERR), 1);
    check_eq("run_b_done", int'(TRAIN_DONE), 0);
    check_eq("run_b_err_lanes", int'(ERR_LANES), 4);
    check_eq("run_b_err_lanes_model", int'(ERR_LANES), int'(err_mask));

    // Run C: reset while lane 1 is centring, then retrain from scratch.
    set_lane(0, 10, 20, 1000);
    set_lane(1, 30, 40, 1000);
    set_lane(2, 50, 70, 1000);
    set_lane(3, 90, 100, 1000);
    push_run(err_mask);
    pulse_start();
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_MOVE[1] && !DELAY_LINE_DIRECTION[1]) seen = 1;
    end
    check_eq("lane1_centering_seen", int'(seen), 1);
    ARST_N = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    repeat (3) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (50) @(negedge FAB_CLK);
    check_eq("no_resume_busy", int'(TRAIN_BUSY), 0);
    check_eq("no_resume_done", int'(TRAIN_DONE), 0);
    push_run(err_mask);
    pulse_start();
    wait_idle("run_c", 30000);
    check_eq("run_c_done", int'(TRAIN_DONE), 1);
    check_eq("run_c_err_lanes", int'(ERR_LANES), int'(err_mask));

    repeat (5) @(negedge FAB_CLK);
    check_eq("pulse_spacing_ok", int'(min_gap >= SC + 1), 1);
    check_eq("move_lane_select", bad_sel, 0);
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
